// File: rtl/sdram_client_responder.sv
// rtl/sdram_client_responder.sv - client burst responder with priority hand-off of the SDRAM controller port
module sdram_client_responder #(
    parameter int         ADDR_WIDTH = 22,
    parameter int         DATA_WIDTH = 32,
    parameter logic [1:0] CMD_IDLE   = 2'd0,
    parameter logic [1:0] CMD_READ   = 2'd1,
    parameter logic [1:0] CMD_WRITE  = 2'd2
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset,
    input  logic [1:0]            i_Command,
    input  logic [ADDR_WIDTH-1:0] i_Data_Address,
    input  logic [DATA_WIDTH-1:0] i_Data_Write,
    output logic [DATA_WIDTH-1:0] o_Data_Read,
    output logic                  o_Data_Read_Valid,
    output logic                  o_Data_Write_Done,
    output logic                  o_SDRAM_Requested,
    input  logic                  i_SDRAM_Yield,
    input  logic                  i_Prio_Req,
    output logic                  o_Prio_Grant,
    input  logic                  i_Prio_Ctl_Req,
    input  logic                  i_Prio_Write,
    input  logic [ADDR_WIDTH-1:0] i_Prio_Addr,
    input  logic [DATA_WIDTH-1:0] i_Prio_WData,
    output logic                  o_Prio_Ack,
    output logic                  o_Prio_RValid,
    output logic                  o_Ctl_Req,
    output logic                  o_Ctl_Write,
    output logic [ADDR_WIDTH-1:0] o_Ctl_Addr,
    output logic [DATA_WIDTH-1:0] o_Ctl_WData,
    input  logic                  i_Ctl_Ack,
    input  logic                  i_Ctl_RValid,
    input  logic [DATA_WIDTH-1:0] i_Ctl_RData
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DATA,
        S_STROBE,
        S_PRIO
    } state_t;

    state_t                  state, state_d;
    logic                    ctl_req_q, ctl_write_q;
    logic [ADDR_WIDTH-1:0]   ctl_addr_q;
    logic [DATA_WIDTH-1:0]   ctl_wdata_q;
    logic                    grant_d, read_done, write_done;
    logic                    ack_hit, cmd_valid;

    // the reserved encoding 2'd3 is treated like idle
    assign cmd_valid = (i_Command != CMD_IDLE) &&
                       ((i_Command == CMD_READ) || (i_Command == CMD_WRITE));
    assign ack_hit   = ctl_req_q && i_Ctl_Ack;

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) state <= S_IDLE;
        else         state <= state_d;
    end

    always_comb begin
        state_d    = state;
        grant_d    = o_Prio_Grant;
        read_done  = 1'b0;
        write_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_Prio_Req && i_SDRAM_Yield) begin
                    state_d = S_PRIO;
                    grant_d = 1'b1;
                end else if (cmd_valid) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE:    state_d = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (ack_hit) begin
                    if (ctl_write_q) begin
                        write_done = 1'b1;
                        state_d    = S_STROBE;
                    end else if (i_Ctl_RValid) begin
                        read_done = 1'b1;
                        state_d   = S_STROBE;
                    end else begin
                        state_d = S_WAIT_DATA;
                    end
                end
            end
            S_WAIT_DATA: begin
                if (i_Ctl_RValid) begin
                    read_done = 1'b1;
                    state_d   = S_STROBE;
                end
            end
            S_STROBE:   state_d = S_IDLE;
            S_PRIO: begin
                if (!i_Prio_Req) begin
                    grant_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            o_Data_Read       <= '0;
            o_Data_Read_Valid <= 1'b0;
            o_Data_Write_Done <= 1'b0;
            o_SDRAM_Requested <= 1'b0;
            o_Prio_Grant      <= 1'b0;
            ctl_req_q         <= 1'b0;
            ctl_write_q       <= 1'b0;
            ctl_addr_q        <= '0;
            ctl_wdata_q       <= '0;
        end else begin
            o_Prio_Grant      <= grant_d;
            // computed from the next grant so the request never overlaps the grant
            o_SDRAM_Requested <= i_Prio_Req && !grant_d;
            o_Data_Read_Valid <= read_done;
            o_Data_Write_Done <= write_done;
            if (read_done) o_Data_Read <= i_Ctl_RData;
            if (state == S_ISSUE) begin
                ctl_addr_q  <= i_Data_Address;
                ctl_wdata_q <= i_Data_Write;
                ctl_write_q <= (i_Command == CMD_WRITE);
                ctl_req_q   <= 1'b1;
            end else if (ack_hit) begin
                ctl_req_q <= 1'b0;
            end
        end
    end

    // while granted, the priority requester drives the controller port directly
    assign o_Ctl_Req     = o_Prio_Grant ? i_Prio_Ctl_Req : ctl_req_q;
    assign o_Ctl_Write   = o_Prio_Grant ? i_Prio_Write   : ctl_write_q;
    assign o_Ctl_Addr    = o_Prio_Grant ? i_Prio_Addr    : ctl_addr_q;
    assign o_Ctl_WData   = o_Prio_Grant ? i_Prio_WData   : ctl_wdata_q;
    assign o_Prio_Ack    = o_Prio_Grant && i_Ctl_Ack;
    assign o_Prio_RValid = o_Prio_Grant && i_Ctl_RValid;

endmodule

// File: tb/tb_sdram_client_responder.sv
// tb/tb_sdram_client_responder.sv - directed and randomized bench for sdram_client_responder
module tb_sdram_client_responder;

    localparam int         AW        = 22;
    localparam int         DW        = 32;
    localparam logic [1:0] CMD_IDLE  = 2'd0;
    localparam logic [1:0] CMD_READ  = 2'd1;
    localparam logic [1:0] CMD_WRITE = 2'd2;

    logic          i_Clk = 1'b0;
    logic          i_Reset;
    logic [1:0]    i_Command;
    logic [AW-1:0] i_Data_Address;
    logic [DW-1:0] i_Data_Write;
    logic [DW-1:0] o_Data_Read;
    logic          o_Data_Read_Valid, o_Data_Write_Done, o_SDRAM_Requested;
    logic          i_SDRAM_Yield, i_Prio_Req, o_Prio_Grant;
    logic          i_Prio_Ctl_Req, i_Prio_Write;
    logic [AW-1:0] i_Prio_Addr;
    logic [DW-1:0] i_Prio_WData;
    logic          o_Prio_Ack, o_Prio_RValid;
    logic          o_Ctl_Req, o_Ctl_Write;
    logic [AW-1:0] o_Ctl_Addr;
    logic [DW-1:0] o_Ctl_WData;
    logic          i_Ctl_Ack, i_Ctl_RValid;
    logic [DW-1:0] i_Ctl_RData;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int acc_cnt = 0;
    int prio_strobe = 0;
    logic [DW-1:0] mem [int];

    sdram_client_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .CMD_IDLE(CMD_IDLE), .CMD_READ(CMD_READ), .CMD_WRITE(CMD_WRITE)
    ) dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Command(i_Command),
        .i_Data_Address(i_Data_Address), .i_Data_Write(i_Data_Write),
        .o_Data_Read(o_Data_Read), .o_Data_Read_Valid(o_Data_Read_Valid),
        .o_Data_Write_Done(o_Data_Write_Done), .o_SDRAM_Requested(o_SDRAM_Requested),
        .i_SDRAM_Yield(i_SDRAM_Yield), .i_Prio_Req(i_Prio_Req), .o_Prio_Grant(o_Prio_Grant),
        .i_Prio_Ctl_Req(i_Prio_Ctl_Req), .i_Prio_Write(i_Prio_Write),
        .i_Prio_Addr(i_Prio_Addr), .i_Prio_WData(i_Prio_WData),
        .o_Prio_Ack(o_Prio_Ack), .o_Prio_RValid(o_Prio_RValid),
        .o_Ctl_Req(o_Ctl_Req), .o_Ctl_Write(o_Ctl_Write), .o_Ctl_Addr(o_Ctl_Addr),
        .o_Ctl_WData(o_Ctl_WData), .i_Ctl_Ack(i_Ctl_Ack), .i_Ctl_RValid(i_Ctl_RValid),
        .i_Ctl_RData(i_Ctl_RData)
    );

    initial forever #5 i_Clk = ~i_Clk;

    always @(posedge i_Clk) cyc <= cyc + 1;

    always @(negedge i_Clk) begin
        if (o_Data_Read_Valid) rd_cnt++;
        if (o_Data_Write_Done) wr_cnt++;
        if (o_Ctl_Req && i_Ctl_Ack && !o_Prio_Grant) acc_cnt++;
        if (o_Prio_Grant && (o_Data_Read_Valid || o_Data_Write_Done)) prio_strobe++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    // one client word: the bench plays both the client and the controller
    task automatic client_word(input logic [1:0] cmd, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input int ack_dly, input int rv_dly,
                               input logic [DW-1:0] rdata, output int strobe_cyc);
        int  n;
        bit  is_wr;
        is_wr = (cmd == CMD_WRITE);
        i_Command      = cmd;
        i_Data_Address = addr;
        i_Data_Write   = wdata;
        n = 0;
        do begin
            tick();
            n++;
        end while (!o_Ctl_Req && n < 20);
        chk("req_seen", o_Ctl_Req, 1'b1);
        repeat (ack_dly) tick();
        chk("req_held", o_Ctl_Req, 1'b1);
        chk("ctl_write", o_Ctl_Write, is_wr);
        chk("ctl_addr", o_Ctl_Addr, addr);
        if (is_wr) chk("ctl_wdata", o_Ctl_WData, wdata);
        i_Ctl_Ack = 1'b1;
        if (!is_wr && rv_dly == 0) begin
            i_Ctl_RValid = 1'b1;
            i_Ctl_RData  = rdata;
        end
        tick();
        i_Ctl_Ack    = 1'b0;
        i_Ctl_RValid = 1'b0;
        if (!is_wr && rv_dly > 0) begin
            chk("no_early_rvalid", o_Data_Read_Valid, 1'b0);
            repeat (rv_dly - 1) tick();
            i_Ctl_RValid = 1'b1;
            i_Ctl_RData  = rdata;
            tick();
            i_Ctl_RValid = 1'b0;
        end
        chk("write_done", o_Data_Write_Done, is_wr);
        chk("read_valid", o_Data_Read_Valid, !is_wr);
        if (!is_wr) chk("read_data", o_Data_Read, rdata);
        chk("req_dropped", o_Ctl_Req, 1'b0);
        strobe_cyc = cyc;
    endtask

    initial begin
        int            sc [8];
        int            dummy, rd0, wr0, acc0;
        logic [AW-1:0] a, base;
        logic [DW-1:0] d;
        logic [1:0]    c;

        i_Reset = 1'b1;
        i_Command = CMD_IDLE; i_Data_Address = '0; i_Data_Write = '0;
        i_SDRAM_Yield = 1'b0; i_Prio_Req = 1'b0; i_Prio_Ctl_Req = 1'b0; i_Prio_Write = 1'b0;
        i_Prio_Addr = '0; i_Prio_WData = '0;
        i_Ctl_Ack = 1'b0; i_Ctl_RValid = 1'b0; i_Ctl_RData = '0;
        repeat (3) tick();
        chk("rst_ctl_req", o_Ctl_Req, 1'b0);
        chk("rst_ctl_addr", o_Ctl_Addr, 0);
        chk("rst_ctl_wdata", o_Ctl_WData, 0);
        chk("rst_data_read", o_Data_Read, 0);
        chk("rst_strobes", {o_Data_Read_Valid, o_Data_Write_Done}, 0);
        chk("rst_prio", {o_Prio_Grant, o_SDRAM_Requested, o_Prio_Ack, o_Prio_RValid}, 0);
        i_Reset = 1'b0;
        tick();
        chk("idle_no_req", o_Ctl_Req, 1'b0);

        // write burst of 8 at 0x100, ack in the cycle after req rises
        base = 22'h000100;
        for (int i = 0; i < 8; i++) begin
            a = base + AW'(i);
            d = $urandom;
            client_word(CMD_WRITE, a, d, 0, 0, '0, sc[i]);
        end
        i_Command = CMD_IDLE;
        for (int i = 1; i < 8; i++) chk("wr_spacing", sc[i] - sc[i-1], 4);
        tick(); tick();
        chk("wr_count", wr_cnt, 8);
        chk("wr_no_reads", rd_cnt, 0);
        chk("wr_accepted", acc_cnt, 8);

        // read burst of 8, RValid three cycles after ack
        base = 22'h000200;
        for (int i = 0; i < 8; i++) begin
            a = base + AW'(i);
            client_word(CMD_READ, a, '0, 0, 3, 32'hA5A50000 + DW'(i), dummy);
        end
        i_Command = CMD_IDLE;
        tick(); tick();
        chk("rd_count", rd_cnt, 8);

        // priority request arrives mid-burst
        base = 22'h000300;
        rd0 = rd_cnt;
        for (int i = 0; i < 8; i++) begin
            a = base + AW'(i);
            client_word(CMD_READ, a, '0, $urandom_range(0, 2), $urandom_range(0, 3), $urandom, dummy);
            if (i == 2) begin
                i_Prio_Req = 1'b1;
                i_Data_Address = base + AW'(3);
                tick();
                chk("requested_set", o_SDRAM_Requested, 1'b1);
                chk("no_grant_mid_burst", o_Prio_Grant, 1'b0);
            end
        end
        i_Command = CMD_IDLE;
        tick();
        chk("burst_complete", rd_cnt - rd0, 8);
        chk("grant_before_yield", o_Prio_Grant, 1'b0);
        chk("requested_held", o_SDRAM_Requested, 1'b1);
        i_SDRAM_Yield = 1'b1;
        tick();
        chk("grant_after_yield", o_Prio_Grant, 1'b1);
        chk("prio_idle_req", o_Ctl_Req, 1'b0);
        i_Prio_Ctl_Req = 1'b1; i_Prio_Write = 1'b0; i_Prio_Addr = 22'h3FFFFF;
        #1;
        chk("prio_ctl_req", o_Ctl_Req, 1'b1);
        chk("prio_ctl_addr", o_Ctl_Addr, 22'h3FFFFF);
        chk("prio_ctl_write", o_Ctl_Write, 1'b0);
        i_Ctl_Ack = 1'b1;
        #1;
        chk("prio_ack", o_Prio_Ack, 1'b1);
        tick();
        i_Ctl_Ack = 1'b0; i_Prio_Ctl_Req = 1'b0;
        i_Ctl_RValid = 1'b1; i_Ctl_RData = $urandom;
        #1;
        chk("prio_ack_low", o_Prio_Ack, 1'b0);
        chk("prio_rvalid", o_Prio_RValid, 1'b1);
        tick();
        i_Ctl_RValid = 1'b0;
        chk("prio_no_client_strobe", o_Data_Read_Valid, 1'b0);

        // priority release, client resumes at the next address
        rd0 = rd_cnt;
        i_Prio_Req = 1'b0; i_SDRAM_Yield = 1'b0;
        i_Command = CMD_READ; i_Data_Address = base + AW'(8);
        tick();
        chk("grant_dropped", o_Prio_Grant, 1'b0);
        chk("release_req", o_Ctl_Req, 1'b0);
        chk("requested_clear", o_SDRAM_Requested, 1'b0);
        client_word(CMD_READ, base + AW'(8), '0, 1, 2, 32'h600DF00D, dummy);
        i_Command = CMD_IDLE;
        tick(); tick();
        chk("resume_one_strobe", rd_cnt - rd0, 1);
        chk("prio_strobes", prio_strobe, 0);

        // same-cycle ack and RValid
        rd0 = rd_cnt;
        client_word(CMD_READ, 22'h0ABCDE, '0, 1, 0, 32'hC0FFEE11, dummy);
        i_Command = CMD_IDLE;
        tick(); tick();
        chk("same_cycle_single", rd_cnt - rd0, 1);

        // randomized words against a memory model
        acc0 = acc_cnt;
        for (int i = 0; i < 24; i++) begin
            a = AW'($urandom_range(0, 15));
            c = ($urandom_range(0, 1) == 1) ? CMD_WRITE : CMD_READ;
            d = $urandom;
            if (c == CMD_WRITE) begin
                mem[int'(a)] = d;
                client_word(c, a, d, $urandom_range(0, 3), 0, '0, dummy);
            end else begin
                if (!mem.exists(int'(a))) mem[int'(a)] = $urandom;
                client_word(c, a, '0, $urandom_range(0, 3), $urandom_range(0, 3), mem[int'(a)], dummy);
            end
            if ($urandom_range(0, 2) == 0) begin
                i_Command = CMD_IDLE;
                tick();
            end
        end
        i_Command = CMD_IDLE;
        tick();
        chk("rand_accepted", acc_cnt - acc0, 24);

        // asynchronous reset while waiting for ack
        wr0 = wr_cnt;
        i_Command = CMD_WRITE; i_Data_Address = 22'h000777; i_Data_Write = 32'hDEADBEEF;
        dummy = 0;
        do begin
            tick();
            dummy++;
        end while (!o_Ctl_Req && dummy < 20);
        chk("reset_req_seen", o_Ctl_Req, 1'b1);
        #2;
        i_Reset = 1'b1;
        #1;
        chk("async_reset_req", o_Ctl_Req, 1'b0);
        i_Command = CMD_IDLE;
        tick();
        #2;
        i_Reset = 1'b0;
        tick(); tick();
        chk("post_reset_req", o_Ctl_Req, 1'b0);
        chk("reset_no_strobe", wr_cnt - wr0, 0);
        d = $urandom;
        client_word(CMD_WRITE, 22'h000777, d, 0, 0, '0, dummy);
        client_word(CMD_READ, 22'h000777, '0, 2, 1, d, dummy);
        i_Command = CMD_IDLE;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
